rifl_rx_buffer: RTL and testbench

- Receive-side elastic buffer directly downstream of the RIFL frame decoder.
- Accepts the decoder's packed product word {tlast, tkeep, tdata}. The decoder applies no backpressure, so every valid word is either stored or dropped.
- Re-presents stored words as an AXI4-Stream master with full tready handshake to user logic.
- Generates a hysteretic pause request so the link's flow-control path can stop the remote transmitter before the buffer overflows.

---
 rtl/rifl_rx_buffer.sv | 129 ++++++++++++
 tb/tb_rifl_rx_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rifl_rx_buffer.sv
// Receive-side elastic buffer behind the RIFL frame decoder: stores decoder words, replays them
// as an AXI4-Stream master, drops on full with a sticky overflow flag, and raises a hysteretic pause.
module rifl_rx_buffer #(
    parameter int FRAME_WIDTH = 256,
    parameter int DEPTH       = 64,
    parameter int PAUSE_ON    = 48,
    parameter int PAUSE_OFF   = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [FRAME_WIDTH+FRAME_WIDTH/8:0]   rx_axis_product,
    input  logic                                 rx_axis_valid,
    output logic [FRAME_WIDTH-1:0]               m_axis_tdata,
    output logic [FRAME_WIDTH/8-1:0]             m_axis_tkeep,
    output logic                                 m_axis_tlast,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 pause_req,
    output logic                                 overflow,
    output logic [$clog2(DEPTH):0]               occupancy
);

    localparam int KEEP_W = FRAME_WIDTH / 8;
    localparam int PROD_W = FRAME_WIDTH + KEEP_W + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = PTR_W + 1;

    localparam logic [OCC_W-1:0] DEPTH_C     = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] PAUSE_ON_C  = OCC_W'(PAUSE_ON);
    localparam logic [OCC_W-1:0] PAUSE_OFF_C = OCC_W'(PAUSE_OFF);
    localparam logic [OCC_W-1:0] ONE_C       = OCC_W'(1);

    generate
        if (!(PAUSE_OFF < PAUSE_ON && PAUSE_ON <= DEPTH)) begin : g_bad_pause
            $error("rifl_rx_buffer: PAUSE_OFF < PAUSE_ON <= DEPTH is required");
        end
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("rifl_rx_buffer: DEPTH must be a power of 2 and at least 4");
        end
    endgenerate

    logic [PROD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ_q;
    logic [OCC_W-1:0]  occ_next;
    logic [OCC_W-1:0]  ram_count;
    logic [PROD_W-1:0] out_word;
    logic              out_valid;
    logic              pause_q;
    logic              overflow_q;
    logic              wr_en;
    logic              rd_en;
    logic              load_out;
    logic              ram_pop;
    logic              ram_push;

    // The output register is always filled first, so the RAM holds occupancy minus that one word.
    // An empty RAM lets an incoming word skip straight into the output register (1-cycle latency).
    always_comb begin
        wr_en     = rx_axis_valid && (occ_q < DEPTH_C);
        rd_en     = out_valid && m_axis_tready;
        ram_count = occ_q - {{(OCC_W-1){1'b0}}, out_valid};
        load_out  = !out_valid || rd_en;
        ram_pop   = load_out && (ram_count != '0);
        ram_push  = wr_en && !(load_out && (ram_count == '0));
        occ_next  = occ_q;
        if (wr_en && !rd_en) begin
            occ_next = occ_q + ONE_C;
        end else if (!wr_en && rd_en) begin
            occ_next = occ_q - ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_push) begin
            mem[wr_ptr] <= rx_axis_product;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ_q      <= '0;
            out_word   <= '0;
            out_valid  <= 1'b0;
            pause_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            occ_q <= occ_next;
            if (ram_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ram_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (load_out) begin
                if (ram_count != '0) begin
                    out_word  <= mem[rd_ptr];
                    out_valid <= 1'b1;
                end else if (wr_en) begin
                    out_word  <= rx_axis_product;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
            if (rx_axis_valid && (occ_q == DEPTH_C)) begin
                overflow_q <= 1'b1;
            end
            // Between the two thresholds the previous pause state is held.
            if (occ_next >= PAUSE_ON_C) begin
                pause_q <= 1'b1;
            end else if (occ_next <= PAUSE_OFF_C) begin
                pause_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = out_word[FRAME_WIDTH-1:0];
    assign m_axis_tkeep  = out_word[FRAME_WIDTH +: KEEP_W];
    assign m_axis_tlast  = out_word[PROD_W-1];
    assign m_axis_tvalid = out_valid;
    assign pause_req     = pause_q;
    assign overflow      = overflow_q;
    assign occupancy     = occ_q;

endmodule

// File: tb/tb_rifl_rx_buffer.sv
// Scoreboard bench for rifl_rx_buffer: directed writes push expected words into a queue,
// a negedge monitor pops and compares every handshaken output word.
module tb_rifl_rx_buffer;

    localparam int FW = 256;
    localparam int KW = FW / 8;
    localparam int PW = FW + KW + 1;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] rx_axis_product;
    logic          rx_axis_valid;
    logic [FW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          pause_req;
    logic          overflow;
    logic [6:0]    occupancy;

    int n_checks = 0;
    int n_pass   = 0;
    logic [PW-1:0] exp_q[$];

    rifl_rx_buffer #(.FRAME_WIDTH(FW), .DEPTH(DEPTH), .PAUSE_ON(48), .PAUSE_OFF(32)) dut (
        .clk(clk),
        .rst(rst),
        .rx_axis_product(rx_axis_product),
        .rx_axis_valid(rx_axis_valid),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .pause_req(pause_req),
        .overflow(overflow),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mk_word(input int idx, input logic last, input logic [KW-1:0] keep);
        logic [FW-1:0] d;
        for (int k = 0; k < FW / 32; k++) begin
            d[k*32 +: 32] = {8'(k), 8'hA5, 16'(idx)};
        end
        return {last, keep, d};
    endfunction

    task automatic checkOutput(input string name, input logic [PW-1:0] got, input logic [PW-1:0] expv);
        n_checks++;
        if (got === expv) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [PW-1:0] w, input bit accept);
        rx_axis_product = w;
        rx_axis_valid   = 1'b1;
        if (accept) exp_q.push_back(w);
        step(1);
        rx_axis_valid = 1'b0;
    endtask

    // Monitor: every word handed over at the coming edge must be the oldest expected one.
    always @(negedge clk) begin
        if (!rst && m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected word: got %0h expected none", {m_axis_tlast, m_axis_tkeep, m_axis_tdata});
            end else begin
                checkOutput("scoreboard word", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [PW-1:0] w0;
        rst = 1'b1;
        rx_axis_valid = 1'b0;
        rx_axis_product = '0;
        m_axis_tready = 1'b1;
        step(3);
        checkOutput("reset tvalid", m_axis_tvalid, 1'b0);
        checkOutput("reset occupancy", occupancy, 0);
        checkOutput("reset pause", pause_req, 1'b0);
        checkOutput("reset overflow", overflow, 1'b0);
        checkOutput("reset output word", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, '0);
        rst = 1'b0;
        step(2);

        $display("[TB] pass-through");
        applyStimulus(mk_word(1000, 1'b0, '1), 1'b1);
        checkOutput("t1 latency tvalid", m_axis_tvalid, 1'b1);
        checkOutput("t1 latency word", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, mk_word(1000, 1'b0, '1));
        checkOutput("t1 occupancy", occupancy, 1);
        applyStimulus(mk_word(1001, 1'b0, '1), 1'b1);
        checkOutput("t1 no bubble B", m_axis_tvalid, 1'b1);
        applyStimulus(mk_word(1002, 1'b1, 32'h0000FFFF), 1'b1);
        checkOutput("t1 no bubble C", m_axis_tvalid, 1'b1);
        checkOutput("t1 C tlast", m_axis_tlast, 1'b1);
        checkOutput("t1 C tkeep", m_axis_tkeep, 32'h0000FFFF);
        step(1);
        checkOutput("t1 drained tvalid", m_axis_tvalid, 1'b0);
        checkOutput("t1 drained occupancy", occupancy, 0);

        $display("[TB] backpressure hold");
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(mk_word(2000 + i, (i == 4), (i == 2) ? '0 : '1), 1'b1);
        end
        checkOutput("t2 occupancy", occupancy, 5);
        w0 = mk_word(2000, 1'b0, '1);
        for (int i = 0; i < 20; i++) begin
            checkOutput("t2 hold word", {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}, {1'b1, w0});
            step(1);
        end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2 drain tvalid", m_axis_tvalid, 1'b1);
            step(1);
        end
        checkOutput("t2 drained tvalid", m_axis_tvalid, 1'b0);
        checkOutput("t2 drained occupancy", occupancy, 0);

        $display("[TB] full and overflow");
        m_axis_tready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            applyStimulus(mk_word(3000 + i, (i % 7 == 6), '1), 1'b1);
        end
        checkOutput("t3 full occupancy", occupancy, 64);
        checkOutput("t3 no overflow yet", overflow, 1'b0);
        checkOutput("t3 pause at full", pause_req, 1'b1);
        applyStimulus(mk_word(3064, 1'b0, '1), 1'b0);
        checkOutput("t3 overflow after 65th", overflow, 1'b1);
        checkOutput("t3 occupancy after drop", occupancy, 64);
        m_axis_tready = 1'b1;
        applyStimulus(mk_word(3065, 1'b0, '1), 1'b0);
        checkOutput("t5 simultaneous occupancy", occupancy, 63);
        checkOutput("t5 simultaneous overflow", overflow, 1'b1);
        step(70);
        checkOutput("t3 all words drained", exp_q.size(), 0);
        checkOutput("t3 final occupancy", occupancy, 0);
        checkOutput("t3 pause cleared", pause_req, 1'b0);

        $display("[TB] pause hysteresis");
        m_axis_tready = 1'b0;
        for (int i = 0; i < 47; i++) begin
            applyStimulus(mk_word(4000 + i, 1'b0, '1), 1'b1);
        end
        checkOutput("t4 pause below on", pause_req, 1'b0);
        applyStimulus(mk_word(4047, 1'b1, '1), 1'b1);
        checkOutput("t4 pause at 48", pause_req, 1'b1);
        m_axis_tready = 1'b1;
        step(8);
        checkOutput("t4 occupancy 40", occupancy, 40);
        checkOutput("t4 pause held at 40", pause_req, 1'b1);
        step(7);
        checkOutput("t4 pause held at 33", pause_req, 1'b1);
        step(1);
        checkOutput("t4 occupancy 32", occupancy, 32);
        checkOutput("t4 pause off at 32", pause_req, 1'b0);
        step(40);
        checkOutput("t4 drained occupancy", occupancy, 0);

        $display("[TB] reset mid-operation");
        m_axis_tready = 1'b0;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(mk_word(5000 + i, 1'b0, '1), 1'b1);
        end
        checkOutput("t6 pre occupancy", occupancy, 50);
        checkOutput("t6 pre pause", pause_req, 1'b1);
        checkOutput("t6 overflow sticky", overflow, 1'b1);
        rst = 1'b1;
        step(1);
        exp_q.delete();
        checkOutput("t6 reset tvalid", m_axis_tvalid, 1'b0);
        checkOutput("t6 reset occupancy", occupancy, 0);
        checkOutput("t6 reset pause", pause_req, 1'b0);
        checkOutput("t6 reset overflow", overflow, 1'b0);
        checkOutput("t6 reset word", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, '0);
        rst = 1'b0;
        m_axis_tready = 1'b1;
        applyStimulus(mk_word(6000, 1'b1, 32'h0000000F), 1'b1);
        checkOutput("t6 post-reset tvalid", m_axis_tvalid, 1'b1);
        checkOutput("t6 post-reset word", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, mk_word(6000, 1'b1, 32'h0000000F));
        step(2);
        checkOutput("t6 post-reset drained", exp_q.size(), 0);
        checkOutput("t6 post-reset occupancy", occupancy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
